// File: rtl/cacheline_burst_adaptor.sv
// Cache-line to memory-burst adaptor: one line request becomes BURSTS memory beats.
// Write lines are sent beat by beat, and read beats are assembled into one line.
module cacheline_burst_adaptor #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64,
    parameter int unsigned BURSTS  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    output logic               resp_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    output logic [BURST_W-1:0] burst_o,
    input  logic [BURST_W-1:0] burst_i,
    input  logic               resp_i
);

    localparam int unsigned CNT_W = (BURSTS > 1) ? $clog2(BURSTS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURSTS - 1);
    // Clears the byte offset within a line.
    localparam logic [31:0] ADDR_MASK = ~(32'(LINE_W / 8) - 32'd1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    if (LINE_W != BURST_W * BURSTS) begin : g_bad_geometry
        $error("LINE_W must equal BURST_W * BURSTS");
    end

    logic [1:0]        state;
    logic [CNT_W-1:0]  count;
    logic [31:0]       addr_reg;
    logic [LINE_W-1:0] wr_line;
    logic [LINE_W-1:0] rd_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            addr_reg <= '0;
            wr_line  <= '0;
            rd_line  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A simultaneous write request is dropped, not queued.
                    if (read_i) begin
                        addr_reg <= address_i & ADDR_MASK;
                        state    <= ST_RD;
                    end else if (write_i) begin
                        addr_reg <= address_i & ADDR_MASK;
                        wr_line  <= line_i;
                        state    <= ST_WR;
                    end
                end
                ST_RD: begin
                    if (resp_i) begin
                        rd_line[count*BURST_W +: BURST_W] <= burst_i;
                        if (count == LAST_BEAT) begin
                            state <= ST_DONE;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                ST_WR: begin
                    if (resp_i) begin
                        if (count == LAST_BEAT) begin
                            state <= ST_DONE;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    count <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        address_o = addr_reg;
        line_o    = rd_line;
        read_o    = (state == ST_RD);
        write_o   = (state == ST_WR);
        resp_o    = (state == ST_DONE);
        burst_o   = '0;
        if (state == ST_WR) begin
            burst_o = wr_line[count*BURST_W +: BURST_W];
        end
    end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for cacheline_burst_adaptor; each task drives one scenario and
// checks outputs 1 time unit after the rising edge.
module tb_cacheline_burst_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i;
    logic         resp_i;

    int checks = 0;
    int errors = 0;

    logic [63:0] beats [4];
    logic [255:0] exp_line;

    cacheline_burst_adaptor #(
        .LINE_W (256),
        .BURST_W(64),
        .BURSTS (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .address_i(address_i),
        .read_i   (read_i),
        .write_i  (write_i),
        .line_i   (line_i),
        .line_o   (line_o),
        .resp_o   (resp_o),
        .address_o(address_o),
        .read_o   (read_o),
        .write_o  (write_o),
        .burst_o  (burst_o),
        .burst_i  (burst_i),
        .resp_i   (resp_i)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; address_i = '0; read_i = 0; write_i = 0; line_i = '0;
        burst_i = '0; resp_i = 0;
        step(); step();
        checks++;
        if ({read_o, write_o, resp_o} !== 3'b000 || address_o !== 32'h0 ||
            line_o !== 256'h0 || burst_o !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs got rd=%b wr=%b resp=%b addr=%h line=%h burst=%h exp all 0",
                     read_o, write_o, resp_o, address_o, line_o, burst_o);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_read();
        beats[0] = {16{4'h1}}; beats[1] = {16{4'h2}};
        beats[2] = {16{4'h3}}; beats[3] = {16{4'h4}};
        address_i = 32'h0000_1234; read_i = 1;
        step();
        read_i = 0; address_i = 32'hFFFF_FFFF;
        checks++;
        if (read_o !== 1'b1 || address_o !== 32'h0000_1220) begin
            errors++;
            $display("FAIL rd_start got rd=%b addr=%h exp rd=1 addr=00001220", read_o, address_o);
        end
        for (int k = 0; k < 4; k++) begin
            resp_i = 1; burst_i = beats[k];
            checks++;
            if (read_o !== 1'b1 || resp_o !== 1'b0 || address_o !== 32'h0000_1220) begin
                errors++;
                $display("FAIL rd_beat%0d got rd=%b resp=%b addr=%h exp 1 0 00001220",
                         k, read_o, resp_o, address_o);
            end
            step();
        end
        resp_i = 0;
        exp_line = {beats[3], beats[2], beats[1], beats[0]};
        checks++;
        if (resp_o !== 1'b1 || read_o !== 1'b0 || line_o !== exp_line) begin
            errors++;
            $display("FAIL rd_done got resp=%b rd=%b line=%h exp 1 0 %h", resp_o, read_o, line_o,
                     exp_line);
        end
        step();
        checks++;
        if (resp_o !== 1'b0 || line_o !== exp_line) begin
            errors++;
            $display("FAIL rd_after got resp=%b line=%h exp 0 %h", resp_o, line_o, exp_line);
        end
    endtask

    task automatic test_write_gaps();
        logic [63:0] d [4];
        int resp_cnt;
        d[0] = 64'hD0D0_0000_0000_00D0; d[1] = 64'hD1D1_1111_1111_11D1;
        d[2] = 64'hD2D2_2222_2222_22D2; d[3] = 64'hD3D3_3333_3333_33D3;
        resp_cnt = 0;
        address_i = 32'h0000_8FFF; line_i = {d[3], d[2], d[1], d[0]}; write_i = 1;
        step();
        write_i = 0; line_i = '1;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < 3; g++) begin
                resp_i = (g == 2);
                checks++;
                if (write_o !== 1'b1 || burst_o !== d[k] || address_o !== 32'h0000_8FE0) begin
                    errors++;
                    $display("FAIL wr_beat%0d_c%0d got wr=%b burst=%h addr=%h exp 1 %h 00008FE0",
                             k, g, write_o, burst_o, address_o, d[k]);
                end
                step();
            end
        end
        resp_i = 0;
        for (int c = 0; c < 3; c++) begin
            if (resp_o === 1'b1) resp_cnt++;
            if (c == 0) begin
                checks++;
                if (write_o !== 1'b0 || resp_o !== 1'b1) begin
                    errors++;
                    $display("FAIL wr_done got wr=%b resp=%b exp 0 1", write_o, resp_o);
                end
            end
            step();
        end
        checks++;
        if (resp_cnt !== 1) begin
            errors++;
            $display("FAIL wr_resp_count got %0d exp 1", resp_cnt);
        end
    endtask

    task automatic test_read_write_collide();
        int resp_cnt;
        int wr_seen;
        resp_cnt = 0; wr_seen = 0;
        address_i = 32'h0000_0040; read_i = 1; write_i = 1; line_i = {4{64'hBAD0_BAD0_BAD0_BAD0}};
        step();
        read_i = 0; write_i = 0;
        checks++;
        if (read_o !== 1'b1 || write_o !== 1'b0) begin
            errors++;
            $display("FAIL coll_start got rd=%b wr=%b exp 1 0", read_o, write_o);
        end
        for (int c = 0; c < 9; c++) begin
            resp_i = (c < 4); burst_i = 64'hC000_0000_0000_0000 | 64'(c);
            if (write_o !== 1'b0) wr_seen++;
            if (resp_o === 1'b1) resp_cnt++;
            step();
        end
        resp_i = 0;
        checks++;
        if (wr_seen !== 0 || resp_cnt !== 1) begin
            errors++;
            $display("FAIL coll_summary got wr_cycles=%0d resp=%0d exp 0 1", wr_seen, resp_cnt);
        end
        exp_line = {64'hC000_0000_0000_0003, 64'hC000_0000_0000_0002,
                    64'hC000_0000_0000_0001, 64'hC000_0000_0000_0000};
        checks++;
        if (line_o !== exp_line) begin
            errors++;
            $display("FAIL coll_line got %h exp %h", line_o, exp_line);
        end
    endtask

    task automatic test_held_read();
        int rd_rises;
        logic prev_rd;
        rd_rises = 0; prev_rd = 0;
        address_i = 32'h0000_2000; read_i = 1;
        step();
        for (int c = 0; c < 5; c++) begin
            resp_i = (c < 4); burst_i = 64'h5555_0000_0000_0000 + 64'(c);
            if (read_o === 1'b1 && prev_rd === 1'b0) rd_rises++;
            prev_rd = read_o;
            if (c == 4) begin
                checks++;
                if (resp_o !== 1'b1) begin
                    errors++;
                    $display("FAIL held_done got resp=%b exp 1", resp_o);
                end
            end
            step();
        end
        read_i = 0; resp_i = 0;
        for (int c = 0; c < 4; c++) begin
            if (read_o === 1'b1 && prev_rd === 1'b0) rd_rises++;
            prev_rd = read_o;
            checks++;
            if (read_o !== 1'b0 || resp_o !== 1'b0) begin
                errors++;
                $display("FAIL held_idle%0d got rd=%b resp=%b exp 0 0", c, read_o, resp_o);
            end
            step();
        end
        checks++;
        if (rd_rises !== 1) begin
            errors++;
            $display("FAIL held_txn_count got %0d exp 1", rd_rises);
        end
    endtask

    task automatic test_reset_mid_read();
        address_i = 32'h0000_3000; read_i = 1;
        step();
        read_i = 0;
        for (int k = 0; k < 2; k++) begin
            resp_i = 1; burst_i = 64'hEEEE_EEEE_0000_0000 + 64'(k);
            step();
        end
        resp_i = 0; rst = 1;
        step();
        rst = 0;
        checks++;
        if ({read_o, write_o, resp_o} !== 3'b000 || address_o !== 32'h0 ||
            line_o !== 256'h0 || burst_o !== 64'h0) begin
            errors++;
            $display("FAIL rst_mid got rd=%b wr=%b resp=%b addr=%h line=%h burst=%h exp all 0",
                     read_o, write_o, resp_o, address_o, line_o, burst_o);
        end
        step();
        checks++;
        if (resp_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_resp got resp=%b exp 0", resp_o);
        end
        address_i = 32'h0000_4010; read_i = 1;
        step();
        read_i = 0;
        for (int k = 0; k < 4; k++) begin
            resp_i = 1; burst_i = 64'hA000_0000_0000_00A0 + 64'(k);
            step();
        end
        resp_i = 0;
        exp_line = {64'hA000_0000_0000_00A3, 64'hA000_0000_0000_00A2,
                    64'hA000_0000_0000_00A1, 64'hA000_0000_0000_00A0};
        checks++;
        if (resp_o !== 1'b1 || line_o !== exp_line || address_o !== 32'h0000_4000) begin
            errors++;
            $display("FAIL rst_fresh got resp=%b line=%h addr=%h exp 1 %h 00004000",
                     resp_o, line_o, address_o, exp_line);
        end
        step();
    endtask

    task automatic test_stray_resp();
        for (int c = 0; c < 4; c++) begin
            resp_i = 1; burst_i = 64'hDEAD_BEEF_0000_0000 + 64'(c);
            step();
            checks++;
            if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0 || line_o !== exp_line) begin
                errors++;
                $display("FAIL stray%0d got resp=%b rd=%b wr=%b line=%h exp 0 0 0 %h",
                         c, resp_o, read_o, write_o, line_o, exp_line);
            end
        end
        resp_i = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_gaps();
        test_read_write_collide();
        test_held_read();
        test_reset_mid_read();
        test_stray_resp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
